// File: rtl/logic_op_engine_pkg.sv
// Shared types for the bit-serial logic-operation engine: opcodes, FSM states
// and the per-bit operation evaluator.
package logic_op_pkg;

    typedef enum logic [2:0] {
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_NAND,
        OP_NOR,
        OP_XNOR,
        OP_NOTA,
        OP_BUFA
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // NOTA and BUFA look only at operand A.
    function automatic logic op_bit(op_e op, logic a, logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_NOTA: r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_op_engine_if.sv
// Command/response handshake bundle between an initiator and the engine.
interface logic_op_engine_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [CNT_W-1:0] rsp_ones;
    logic [2:0]       rsp_op;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ones, rsp_op
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_ones, rsp_op
    );

endinterface

// File: rtl/logic_op_engine_bit.sv
// Combinational single-bit evaluator used by the serial datapath.
module logic_op_bit
    import logic_op_pkg::*;
(
    input  op_e  op,
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = op_bit(op, a, b);

endmodule

// File: rtl/logic_op_engine.sv
// Bit-serial multi-bit logic engine: accepts a command, evaluates one bit per
// clock LSB first, then presents the result and its population count.
module logic_op_engine
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic               clk,
    input  logic               reset,
    logic_op_engine_if.slave   bus,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] ones_reg, ones_next;
    op_e              op_reg;
    logic [IDX_W-1:0] bit_idx_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic [CNT_W-1:0] rsp_ones_reg;
    logic [2:0]       rsp_op_reg;
    logic             rsp_valid_reg;
    logic             busy_reg;
    logic             bit_val;
    logic             last_bit;

    logic_op_bit u_bit (
        .op (op_reg),
        .a  (a_reg[0]),
        .b  (b_reg[0]),
        .y  (bit_val)
    );

    assign last_bit = (bit_idx_reg == IDX_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        // New bit enters at the MSB so after WIDTH shifts bit i lands at i.
        acc_next            = acc_reg >> 1;
        acc_next[WIDTH-1]   = bit_val;
        ones_next           = ones_reg + CNT_W'(bit_val);
        case (state_reg)
            IDLE:    if (bus.cmd_valid) state_next = RUN;
            RUN:     if (last_bit)      state_next = DONE;
            DONE:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= OP_AND;
            acc_reg       <= '0;
            ones_reg      <= '0;
            bit_idx_reg   <= '0;
            rsp_data_reg  <= '0;
            rsp_ones_reg  <= '0;
            rsp_op_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            busy_reg      <= (state_next != IDLE);
            rsp_valid_reg <= (state_next == DONE);
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        a_reg       <= bus.cmd_a;
                        b_reg       <= bus.cmd_b;
                        op_reg      <= op_e'(bus.cmd_op);
                        acc_reg     <= '0;
                        ones_reg    <= '0;
                        bit_idx_reg <= '0;
                    end
                end
                RUN: begin
                    a_reg       <= a_reg >> 1;
                    b_reg       <= b_reg >> 1;
                    acc_reg     <= acc_next;
                    ones_reg    <= ones_next;
                    bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                    // Response registers change only here, so they hold
                    // through IDLE and the next RUN.
                    if (last_bit) begin
                        rsp_data_reg <= acc_next;
                        rsp_ones_reg <= ones_next;
                        rsp_op_reg   <= op_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_ones  = rsp_ones_reg;
    assign bus.rsp_op    = rsp_op_reg;
    assign busy          = busy_reg;

endmodule

// File: doc/logic_op_engine.md
Name: logic_op_engine

Overview:
- Bit-serial, multi-bit logic-operation responder. Accepts one command (3-bit opcode, two WIDTH-bit operands) over a valid/ready handshake.
- Evaluates the operation one bit per clock, LSB first, then returns the result and its population count over a second valid/ready handshake.
- Sits behind the single-bit logic_operations unit as the multi-bit, flow-controlled counterpart that a command initiator or sequencer drives.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), derived localparam, width of rsp_ones; not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  engine can accept a command
- cmd_op  input  3  opcode
- cmd_a  input  WIDTH  operand A (inp_1 side)
- cmd_b  input  WIDTH  operand B (inp_2 side)
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  WIDTH  result
- rsp_ones  output  CNT_W  number of 1 bits in rsp_data
- rsp_op  output  3  echo of the accepted opcode
- busy  output  1  high in RUN or DONE

Behaviour:
- Opcodes (op_cntrl encoding, per bit):
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR
  - 6 NOT A (B ignored), 7 BUF A (B ignored)
- Reset, sampled at the clock edge, overrides everything:
  - state <= IDLE
  - rsp_valid, rsp_data, rsp_ones, rsp_op, bit counter, busy all <= 0
  - cmd_ready = 1 from the first cycle after reset deasserts
- FSM IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, load shift registers A and B and the opcode, clear the result and ones accumulators, set bit_idx = 0, and go to RUN.
  - cmd_* are sampled only at acceptance; later changes have no effect.
- FSM RUN:
  - cmd_ready = 0.
  - Each cycle: compute the result bit from A[0], B[0] and the opcode; shift it into the result MSB-first so that after WIDTH shifts bit i sits at position i; add it to rsp_ones; shift A and B right; bit_idx++.
  - When bit_idx == WIDTH-1, go to DONE.
  - RUN lasts exactly WIDTH cycles. With WIDTH = 1 it lasts 1 cycle.
- FSM DONE:
  - rsp_valid = 1, registered.
  - rsp_data, rsp_ones and rsp_op stay stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE and clear rsp_valid on the same edge. rsp_data, rsp_ones and rsp_op hold their last values.
- Latency: if a command is accepted at edge E, rsp_valid is high after edge E+WIDTH. The earliest next acceptance is at the edge after the response handshake, so throughput is one command per WIDTH+2 cycles minimum.
- Simultaneous events:
  - cmd_valid during RUN or DONE is ignored and not queued; the initiator must hold it.
  - rsp_ready outside DONE has no effect.
- Reset mid-operation (RUN or DONE): the in-flight command is discarded, no response is produced, and outputs go to their reset values.
- Width rules:
  - rsp_ones range is 0..WIDTH; CNT_W guarantees no overflow.
  - bit_idx is $clog2(WIDTH) bits, minimum 1.
- No combinational path from cmd_* to rsp_*; cmd_ready depends only on state.

Decomposition:
- Package logic_op_pkg:
  - typedef enum logic [2:0] op_e {OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOTA, OP_BUFA}
  - typedef enum state_e {IDLE, RUN, DONE}
  - function logic op_bit(op_e, logic a, logic b)
- One natural sub-module: logic_op_bit, a combinational single-bit evaluator wrapping op_bit. The engine instantiates it once on A[0]/B[0].

Test Plan:
- Reset checks:
  - Hold reset for 3 cycles: all outputs 0 and cmd_ready 1 after release.
  - Assert reset in DONE: rsp_valid drops after that edge.
- AND: op=0, A=8'hF0, B=8'h3C, accepted at edge E -> rsp_valid high after E+8, rsp_data=8'h30, rsp_ones=2, rsp_op=0, busy high from E+1 until the handshake.
- All-zero and all-one results:
  - op=4 (NOR), A=B=8'h00 -> rsp_data=8'hFF, rsp_ones=8
  - op=5 (XNOR), A=8'hAA, B=8'h55 -> rsp_data=8'h00, rsp_ones=0
- Operand-B-ignored ops:
  - op=6, A=8'h0F, B=8'hFF -> 8'hF0, ones=4
  - op=7, A=8'h81, B=8'h7E -> 8'h81, ones=2
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE while driving cmd_valid=1 with a new command -> rsp_* stable, cmd_ready=0, and the new command is accepted only on the edge after the rsp_valid && rsp_ready handshake.
- Reset mid-RUN: accept op=1, A=8'h01, B=8'h02, assert reset on the 4th RUN cycle -> no rsp_valid ever appears, cmd_ready=1 the cycle after reset releases, and the next command (op=2, 8'hFF^8'h0F) returns 8'hF0, ones=4.
